// File: rtl/kernel3x3_stream.sv
// kernel3x3_stream: streaming 3x3 neighbourhood filter (bypass, Sobel-x/y, magnitude, Gaussian blur).
// Latency: fixed 3 clocks from an accepted iDVAL to oDVAL; 1 pixel/clock with arbitrary input gaps.
// Backpressure: none; the pipeline free-runs and never stalls or reorders.
// Optional: define KERNEL3X3_THRESH_EN to add iTHRESH and binarise the edge modes (1-3).
module kernel3x3_stream #(
   parameter int PIX_W   = 12,
   parameter int LINE_W  = 640,
   parameter int FRAME_H = 480
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   input  logic [PIX_W-1:0] iPIX,
   input  logic             iDVAL,
   input  logic             iSOF,
   input  logic [2:0]       iMODE,
`ifdef KERNEL3X3_THRESH_EN
   input  logic [PIX_W-1:0] iTHRESH,
`endif
   output logic [PIX_W-1:0] oPIX,
   output logic             oDVAL,
   output logic             oEOF
);

   localparam int XW = (LINE_W  > 1) ? $clog2(LINE_W)  : 1;
   localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
   // Kernel sums need 4 guard bits over the pixel width: |Gx|,|Gy| <= 4*max, blur sum <= 16*max.
   localparam int SW = PIX_W + 4;

   localparam logic [XW-1:0]    X_LAST  = XW'(LINE_W - 1);
   localparam logic [YW-1:0]    Y_LAST  = YW'(FRAME_H - 1);
   localparam logic [XW-1:0]    X_TWO   = XW'(2);
   localparam logic [YW-1:0]    Y_TWO   = YW'(2);
   localparam logic [PIX_W-1:0] PIX_MAX = '1;

   localparam logic [2:0] M_BYP = 3'd0;
   localparam logic [2:0] M_HOR = 3'd1;
   localparam logic [2:0] M_VER = 3'd2;
   localparam logic [2:0] M_MAG = 3'd3;
   localparam logic [2:0] M_GAU = 3'd4;

   // ------------------------------------------------------------------
   // Position counters and per-frame mode latch
   // ------------------------------------------------------------------
   logic [XW-1:0] x_q, x_d, cur_x;
   logic [YW-1:0] y_q, y_d, cur_y;
   logic [2:0]    mode_q, mode_d, pix_mode;
   logic          mode_seen_q, mode_seen_d;
   logic          sample_mode;

   // Resolve the incoming pixel's coordinate (SOF resyncs to 0,0) and the next counter/mode state
   always_comb begin
      cur_x       = iSOF ? '0 : x_q;
      cur_y       = iSOF ? '0 : y_q;
      x_d         = x_q;
      y_d         = y_q;
      mode_d      = mode_q;
      mode_seen_d = mode_seen_q;
      // The mode is only sampled at frame start, or on the very first pixel after reset
      sample_mode = iDVAL && (iSOF || !mode_seen_q);
      if (iDVAL) begin
         if (cur_x == X_LAST) begin
            x_d = '0;
            y_d = (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
         end else begin
            x_d = cur_x + 1'b1;
            y_d = cur_y;
         end
      end
      if (sample_mode) begin
         mode_d      = iMODE;
         mode_seen_d = 1'b1;
      end
      // Effective mode for this pixel; codes 5-7 collapse to bypass
      pix_mode = sample_mode ? iMODE : mode_q;
      if (pix_mode > M_GAU) begin
         pix_mode = M_BYP;
      end
   end

   // Register counters and latched mode
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         x_q         <= '0;
         y_q         <= '0;
         mode_q      <= M_BYP;
         mode_seen_q <= 1'b0;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         mode_q      <= mode_d;
         mode_seen_q <= mode_seen_d;
      end
   end

   // ------------------------------------------------------------------
   // Line buffers: lb1 holds row y-1, lb2 holds row y-2, both indexed by x
   // ------------------------------------------------------------------
   logic [PIX_W-1:0] lb1_mem [LINE_W];
   logic [PIX_W-1:0] lb2_mem [LINE_W];
   logic [PIX_W-1:0] lb1_rd, lb2_rd;

   assign lb1_rd = lb1_mem[cur_x];
   assign lb2_rd = lb2_mem[cur_x];

   // Read-then-write in the same cycle: the new pixel replaces row y-1, and row y-1 ages into row y-2.
   // Contents are never cleared; stale data only reaches border outputs, which are masked.
   always_ff @(posedge iCLK) begin
      if (iDVAL) begin
         lb1_mem[cur_x] <= iPIX;
         lb2_mem[cur_x] <= lb1_rd;
      end
   end

   // ------------------------------------------------------------------
   // S1: 3x3 window, win_q[row][col], row 0 oldest, col 0 leftmost
   // ------------------------------------------------------------------
   logic [2:0][2:0][PIX_W-1:0] win_q;
   logic                       s1_vld_q, s1_border_q, s1_eof_q;
   logic [2:0]                 s1_mode_q;

   // Shift the window one column per accepted pixel and tag border/EOF status
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         win_q       <= '0;
         s1_vld_q    <= 1'b0;
         s1_border_q <= 1'b0;
         s1_eof_q    <= 1'b0;
         s1_mode_q   <= M_BYP;
      end else begin
         s1_vld_q <= iDVAL;
         if (iDVAL) begin
            for (int r = 0; r < 3; r++) begin
               win_q[r][0] <= win_q[r][1];
               win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb2_rd;
            win_q[1][2] <= lb1_rd;
            win_q[2][2] <= iPIX;
            s1_border_q <= (cur_x < X_TWO) || (cur_y < Y_TWO);
            s1_eof_q    <= (cur_x == X_LAST) && (cur_y == Y_LAST);
            s1_mode_q   <= pix_mode;
         end
      end
   end

   // ------------------------------------------------------------------
   // S2: weighted partial sums
   // ------------------------------------------------------------------
   function automatic logic signed [SW-1:0] sx(input logic [PIX_W-1:0] p);
      return $signed({4'b0000, p});
   endfunction

   function automatic logic [SW-1:0] ux(input logic [PIX_W-1:0] p);
      return {4'b0000, p};
   endfunction

   logic signed [SW-1:0] gx_d, gy_d, s2_gx_q, s2_gy_q;
   logic        [SW-1:0] gs_d, s2_gs_q;
   logic [PIX_W-1:0]     s2_p11_q;
   logic                 s2_vld_q, s2_border_q, s2_eof_q;
   logic [2:0]           s2_mode_q;

   // Sobel gradients and the 1-2-1 Gaussian sum from the current window
   always_comb begin
      gx_d = (sx(win_q[0][2]) + (sx(win_q[1][2]) <<< 1) + sx(win_q[2][2]))
           - (sx(win_q[0][0]) + (sx(win_q[1][0]) <<< 1) + sx(win_q[2][0]));
      gy_d = (sx(win_q[2][0]) + (sx(win_q[2][1]) <<< 1) + sx(win_q[2][2]))
           - (sx(win_q[0][0]) + (sx(win_q[0][1]) <<< 1) + sx(win_q[0][2]));
      gs_d = ux(win_q[0][0]) + (ux(win_q[0][1]) << 1) + ux(win_q[0][2])
           + (ux(win_q[1][0]) << 1) + (ux(win_q[1][1]) << 2) + (ux(win_q[1][2]) << 1)
           + ux(win_q[2][0]) + (ux(win_q[2][1]) << 1) + ux(win_q[2][2]);
   end

   // Register sums and carry the sideband along; free-running
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         s2_gx_q     <= '0;
         s2_gy_q     <= '0;
         s2_gs_q     <= '0;
         s2_p11_q    <= '0;
         s2_vld_q    <= 1'b0;
         s2_border_q <= 1'b0;
         s2_eof_q    <= 1'b0;
         s2_mode_q   <= M_BYP;
      end else begin
         s2_gx_q     <= gx_d;
         s2_gy_q     <= gy_d;
         s2_gs_q     <= gs_d;
         s2_p11_q    <= win_q[1][1];
         s2_vld_q    <= s1_vld_q;
         s2_border_q <= s1_border_q;
         s2_eof_q    <= s1_eof_q;
         s2_mode_q   <= s1_mode_q;
      end
   end

   // ------------------------------------------------------------------
   // S3: abs, shift, saturate, border mask, mode mux
   // ------------------------------------------------------------------
   logic [SW-1:0]    ax, ay, mag;
   logic [PIX_W-1:0] edge_h, edge_v, edge_m, blur, res_d;
   logic [PIX_W-1:0] opix_q;
   logic             odval_q, oeof_q;

   // Build each mode's result and select the one latched for this frame
   always_comb begin
      ax     = s2_gx_q[SW-1] ? $unsigned(-s2_gx_q) : $unsigned(s2_gx_q);
      ay     = s2_gy_q[SW-1] ? $unsigned(-s2_gy_q) : $unsigned(s2_gy_q);
      edge_h = PIX_W'(ay >> 2);
      edge_v = PIX_W'(ax >> 2);
      mag    = (ax + ay) >> 2;
      edge_m = (mag > SW'(PIX_MAX)) ? PIX_MAX : PIX_W'(mag);
      blur   = PIX_W'(s2_gs_q >> 4);
`ifdef KERNEL3X3_THRESH_EN
      edge_h = (edge_h >= iTHRESH) ? PIX_MAX : '0;
      edge_v = (edge_v >= iTHRESH) ? PIX_MAX : '0;
      edge_m = (edge_m >= iTHRESH) ? PIX_MAX : '0;
`endif
      case (s2_mode_q)
         M_HOR:   res_d = edge_h;
         M_VER:   res_d = edge_v;
         M_MAG:   res_d = edge_m;
         M_GAU:   res_d = blur;
         default: res_d = s2_p11_q;
      endcase
      // Incomplete windows are zeroed for every filtering mode; bypass passes them through
      if (s2_border_q && (s2_mode_q != M_BYP)) begin
         res_d = '0;
      end
   end

   // Register outputs; oPIX holds between valid outputs
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         opix_q  <= '0;
         odval_q <= 1'b0;
         oeof_q  <= 1'b0;
      end else begin
         odval_q <= s2_vld_q;
         oeof_q  <= s2_vld_q && s2_eof_q;
         if (s2_vld_q) begin
            opix_q <= res_d;
         end
      end
   end

   assign oPIX  = opix_q;
   assign oDVAL = odval_q;
   assign oEOF  = oeof_q;

endmodule

// File: tb/tb_kernel3x3_stream.sv
// Bench for kernel3x3_stream on an 8x4 frame with a reference model and expectation queue.
module tb_kernel3x3_stream;

   localparam int PW = 12;
   localparam int W  = 8;
   localparam int H  = 4;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [PW-1:0] pix;
   logic          dval, sof;
   logic [2:0]    mode;
   logic [PW-1:0] opix;
   logic          odval, oeof;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int img [H][W];

   typedef struct {
      int pix;
      bit eof;
      bit chk;
      int cyc;
   } exp_t;

   exp_t sb [$];
   exp_t got_e;

   kernel3x3_stream #(.PIX_W(PW), .LINE_W(W), .FRAME_H(H)) dut (
      .iCLK   (clk),
      .iRST_N (rst_n),
      .iPIX   (pix),
      .iDVAL  (dval),
      .iSOF   (sof),
      .iMODE  (mode),
      .oPIX   (opix),
      .oDVAL  (odval),
      .oEOF   (oeof)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference filter on the full frame image for the pixel arriving at (x,y)
   function automatic int kexp(input int m, input int x, input int y);
      int p [3][3];
      int gx, gy, ax, ay, s;
      if (x < 2 || y < 2) return 0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            p[r][c] = img[y-2+r][x-2+c];
      gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
      gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      case (m)
         1: return ay / 4;
         2: return ax / 4;
         3: begin
               s = (ax + ay) / 4;
               return (s > 4095) ? 4095 : s;
            end
         4: return (p[0][0] + 2*p[0][1] + p[0][2] + 2*p[1][0] + 4*p[1][1] + 2*p[1][2]
                    + p[2][0] + 2*p[2][1] + p[2][2]) / 16;
         default: return p[1][1];
      endcase
   endfunction

   task automatic push_exp(input int m, input int x, input int y);
      exp_t e;
      int   em;
      em    = (m >= 5) ? 0 : m;
      e.pix = kexp(em, x, y);
      e.chk = !(em == 0 && (x < 2 || y < 2));
      e.eof = (x == W-1 && y == H-1);
      e.cyc = cyc;
      sb.push_back(e);
   endtask

   // Drive up to n_pix pixels of img in mode m; iMODE switches to flip_mode at index flip_at
   task automatic run_frame(input int m, input int n_pix, input int gap_max,
                            input int flip_at, input int flip_mode);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            if (y*W + x < n_pix) begin
               pix  = img[y][x][PW-1:0];
               dval = 1'b1;
               sof  = (x == 0 && y == 0);
               mode = (flip_at >= 0 && y*W + x >= flip_at) ? flip_mode[2:0] : m[2:0];
               push_exp(m, x, y);
               @(posedge clk); #1;
               dval = 1'b0;
               sof  = 1'b0;
               if (gap_max > 0) begin
                  repeat ($urandom_range(gap_max, 0)) begin
                     // SOF without DVAL must be ignored
                     sof = ($urandom_range(1, 0) == 1);
                     pix = PW'($urandom_range(4095, 0));
                     @(posedge clk); #1;
                  end
                  sof = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic fill_random();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            img[y][x] = $urandom_range(4095, 0);
   endtask

   task automatic check_reset_outputs();
      n_vec++;
      assert (opix === '0) else begin n_err++; $error("FAIL rst_opix got %0d want 0", opix); end
      n_vec++;
      assert (odval === 1'b0) else begin n_err++; $error("FAIL rst_odval got %0b want 0", odval); end
      n_vec++;
      assert (oeof === 1'b0) else begin n_err++; $error("FAIL rst_oeof got %0b want 0", oeof); end
   endtask

   // Output monitor: pop one expectation per oDVAL, check latency, EOF and pixel
   always @(negedge clk) begin
      if (rst_n) begin
         if (odval) begin
            n_vec++;
            assert (sb.size() != 0) else begin
               n_err++; $error("FAIL spurious_dval got queue %0d want >0", sb.size());
            end
            if (sb.size() != 0) begin
               got_e = sb.pop_front();
               n_vec++;
               assert (cyc === got_e.cyc + 3) else begin
                  n_err++; $error("FAIL latency got %0d want 3", cyc - got_e.cyc);
               end
               n_vec++;
               assert (oeof === got_e.eof) else begin
                  n_err++; $error("FAIL eof got %0b want %0b", oeof, got_e.eof);
               end
               if (got_e.chk) begin
                  n_vec++;
                  assert (int'(opix) === got_e.pix) else begin
                     n_err++; $error("FAIL pix got %0d want %0d", opix, got_e.pix);
                  end
               end
            end
         end else begin
            n_vec++;
            assert (oeof === 1'b0) else begin
               n_err++; $error("FAIL eof_idle got %0b want 0", oeof);
            end
         end
      end
   end

   initial begin
      pix  = '0;
      dval = 1'b0;
      sof  = 1'b0;
      mode = 3'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Constant frame, magnitude: everything is zero
      for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 100;
      run_frame(3, W*H, 0, -1, 0);

      // Vertical step: Gx mode sees 4000 at the step, Gy mode sees nothing
      for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = (x >= 4) ? 4000 : 0;
      run_frame(2, W*H, 0, -1, 0);
      run_frame(1, W*H, 0, -1, 0);

      // Diagonal step drives the magnitude past full scale
      for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = (x + y >= 5) ? 4095 : 0;
      run_frame(3, W*H, 0, -1, 0);

      // Gaussian impulse response
      for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 0;
      img[2][3] = 1600;
      run_frame(4, W*H, 0, -1, 0);

      // Mid-frame mode change is ignored until the next SOF; gapped runs match gap-free ones
      fill_random();
      run_frame(1, W*H, 0, 13, 3);
      run_frame(1, W*H, 3, 13, 3);
      run_frame(3, W*H, 2, -1, 0);

      // Bypass, including an out-of-range mode code
      fill_random();
      run_frame(0, W*H, 0, -1, 0);
      fill_random();
      run_frame(6, W*H, 1, -1, 0);

      // Reset in the middle of a frame, then a fresh frame
      fill_random();
      run_frame(2, 13, 0, -1, 0);
      rst_n = 1'b0;
      #2;
      check_reset_outputs();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs();
      sb.delete();
      rst_n = 1'b1;
      @(posedge clk); #1;
      fill_random();
      run_frame(3, W*H, 2, -1, 0);

      // Drain with a bounded wait
      for (int i = 0; i < 20; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk); #1;
      end
      n_vec++;
      assert (sb.size() == 0) else begin
         n_err++; $error("FAIL drain got %0d pending want 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
